// File: rtl/lisa_baud_if.sv
// Line and host-side signals of the baud reference generator.
// The slave modport is the generator side, master is the host/line side.
interface lisa_baud_if #(
    parameter int DIV_WIDTH = 16
);
    logic                 rxd;
    logic                 autobaud_en;
    logic                 div_wr;
    logic [DIV_WIDTH-1:0] div_wdata;
    logic                 baud_ref;
    logic [DIV_WIDTH-1:0] divisor;
    logic                 locked;
    logic                 ab_error;

    modport master (
        output rxd, autobaud_en, div_wr, div_wdata,
        input  baud_ref, divisor, locked, ab_error
    );

    modport slave (
        input  rxd, autobaud_en, div_wr, div_wdata,
        output baud_ref, divisor, locked, ab_error
    );
endinterface

// File: rtl/lisa_baud_gen.sv
// 16x baud reference divider with host-written or autobaud-measured divisor.
// Autobaud times four falling edges of a received 0x55 (8 bit times).
module lisa_baud_gen #(
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 27
) (
    input logic        clk,
    input logic        rst_n,
    lisa_baud_if.slave bus
);
    localparam int MW = DIV_WIDTH + 7;
    localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(2);
    localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic                 rxd_s1_q, rxd_s2_q, rxd_prev_q;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 baud_q, baud_d;
    logic                 locked_q, locked_d;
    logic                 err_q, err_d;
    logic [MW-1:0]        meas_q, meas_d;
    logic [1:0]           edges_q, edges_d;

    logic                 fall;
    logic [MW:0]          m_round;
    logic [DIV_WIDTH:0]   result;
    logic                 result_ok;
    logic [DIV_WIDTH-1:0] wr_val;

    assign fall = rxd_prev_q & ~rxd_s2_q;

    // M = meas_q + 1 edge-to-edge cycles; add 64 to round M/128
    assign m_round   = {1'b0, meas_q} + (MW+1)'(65);
    assign result    = (DIV_WIDTH+1)'(m_round >> 7);
    assign result_ok = !result[DIV_WIDTH] &&
                       (result[DIV_WIDTH-1:0] >= MIN_DIV);

    assign wr_val = (bus.div_wdata < MIN_DIV) ? MIN_DIV
                                              : bus.div_wdata;

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        locked_d = locked_q;
        err_d    = err_q;
        meas_d   = meas_q;
        edges_d  = edges_q;
        baud_d   = (cnt_q == '0);
        cnt_d    = baud_d ? div_q - ONE : cnt_q - ONE;

        unique case (state_q)
            IDLE: begin
                if (bus.autobaud_en) begin
                    state_d  = ARM;
                    locked_d = 1'b0;
                    err_d    = 1'b0;
                end
            end
            ARM: begin
                if (!bus.autobaud_en) begin
                    state_d = IDLE;
                end else if (fall) begin
                    state_d = MEASURE;
                    meas_d  = '0;
                    edges_d = '0;
                end
            end
            MEASURE: begin
                if (!bus.autobaud_en) begin
                    state_d = IDLE;
                end else if (fall && edges_q == 2'd3) begin
                    if (result_ok) begin
                        div_d    = result[DIV_WIDTH-1:0];
                        cnt_d    = result[DIV_WIDTH-1:0] - ONE;
                        locked_d = 1'b1;
                        state_d  = DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ARM;
                    end
                end else if (meas_q == '1) begin
                    err_d   = 1'b1;
                    state_d = ARM;
                end else begin
                    meas_d = meas_q + MW'(1);
                    if (fall) begin
                        edges_d = edges_q + 2'd1;
                    end
                end
            end
            DONE: begin
                if (!bus.autobaud_en) begin
                    state_d = IDLE;
                end
            end
        endcase

        // Host write wins over anything the measurement decided
        if (bus.div_wr) begin
            div_d    = wr_val;
            cnt_d    = wr_val - ONE;
            locked_d = 1'b1;
            err_d    = 1'b0;
            if (state_q != IDLE || bus.autobaud_en) begin
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rxd_prev_q <= 1'b1;
            cnt_q      <= DEF_DIV - ONE;
            div_q      <= DEF_DIV;
            baud_q     <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            meas_q     <= '0;
            edges_q    <= '0;
        end else begin
            state_q    <= state_d;
            rxd_s1_q   <= bus.rxd;
            rxd_s2_q   <= rxd_s1_q;
            rxd_prev_q <= rxd_s2_q;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            baud_q     <= baud_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            meas_q     <= meas_d;
            edges_q    <= edges_d;
        end
    end

    assign bus.baud_ref = baud_q;
    assign bus.divisor  = div_q;
    assign bus.locked   = locked_q;
    assign bus.ab_error = err_q;
endmodule

// File: tb/tb_lisa_baud_gen.sv
// Scoreboard bench for lisa_baud_gen: pulse times and status snapshots
// are predicted from the divisor rules and checked by a monitor.
module tb_lisa_baud_gen;
    localparam int W1  = 16;
    localparam int W2  = 8;
    localparam int DEF = 27;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lisa_baud_if #(.DIV_WIDTH(W1)) b1 ();
    lisa_baud_if #(.DIV_WIDTH(W2)) b2 ();

    lisa_baud_gen #(.DIV_WIDTH(W1), .DEFAULT_DIV(DEF)) dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (b1)
    );

    lisa_baud_gen #(.DIV_WIDTH(W2), .DEFAULT_DIV(DEF)) dut2 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (b2)
    );

    typedef struct {
        int id;
        int dv;
        bit lk;
        bit er;
    } st_t;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  exp_q[$];
    st_t st_q[$];

    // Reference state: pulse schedule of dut1 and status of both
    int  m_div = DEF;
    int  m_next = 0;
    int  pend_cyc = -1;
    int  pend_div = 0;
    int  ref_div[2];
    bit  ref_lk[2];
    bit  ref_er[2];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            m_div    = DEF;
            m_next   = cyc + DEF;
            pend_cyc = -1;
        end else begin
            if (cyc == m_next) begin
                exp_q.push_back(cyc);
                m_next = cyc + m_div;
            end
            if (cyc == pend_cyc) begin
                m_div    = pend_div;
                m_next   = cyc + pend_div;
                pend_cyc = -1;
            end
        end
    end

    always @(negedge clk) begin
        int  e;
        st_t s;
        int  adiv;
        bit  alk;
        bit  aer;
        if (b1.baud_ref) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pulse_extra: baud_ref high at cycle %0d, none expected", cyc);
            end else begin
                e = exp_q.pop_front();
                if (e != cyc) begin
                    errors++;
                    $display("FAIL pulse_time: pulse at cycle %0d, expected %0d", cyc, e);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0] <= cyc) begin
            checks++;
            errors++;
            e = exp_q.pop_front();
            $display("FAIL pulse_missing: no pulse at cycle %0d (now %0d)", e, cyc);
        end
        if (st_q.size() > 0) begin
            s = st_q.pop_front();
            if (s.id == 0) begin
                adiv = int'(b1.divisor);
                alk  = b1.locked;
                aer  = b1.ab_error;
            end else begin
                adiv = int'(b2.divisor);
                alk  = b2.locked;
                aer  = b2.ab_error;
            end
            checks += 3;
            if (adiv != s.dv) begin
                errors++;
                $display("FAIL divisor[dut%0d] cyc %0d: got %0d want %0d", s.id, cyc, adiv, s.dv);
            end
            if (alk != s.lk) begin
                errors++;
                $display("FAIL locked[dut%0d] cyc %0d: got %0d want %0d", s.id, cyc, alk, s.lk);
            end
            if (aer != s.er) begin
                errors++;
                $display("FAIL ab_error[dut%0d] cyc %0d: got %0d want %0d", s.id, cyc, aer, s.er);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_status(input int id);
        st_t s;
        s.id = id;
        s.dv = ref_div[id];
        s.lk = ref_lk[id];
        s.er = ref_er[id];
        st_q.push_back(s);
        tick(2);
    endtask

    task automatic set_rxd(input int id, input logic v);
        if (id == 0) b1.rxd = v;
        else b2.rxd = v;
    endtask

    function automatic int ab_result(input int p);
        return (8 * p + 64) / 128;
    endfunction

    task automatic host_write(input int v);
        int nv;
        nv = (v < 2) ? 2 : v;
        b1.div_wr    = 1'b1;
        b1.div_wdata = W1'(v);
        pend_cyc     = cyc + 1;
        pend_div     = nv;
        ref_div[0]   = nv;
        ref_lk[0]    = 1'b1;
        ref_er[0]    = 1'b0;
        tick(1);
        b1.div_wr = 1'b0;
    endtask

    task automatic ab_rearm();
        b1.autobaud_en = 1'b0;
        tick(3);
        b1.autobaud_en = 1'b1;
        tick(3);
        ref_lk[0] = 1'b0;
        ref_er[0] = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        tick(n);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ref_div[i] = DEF;
            ref_lk[i]  = 1'b0;
            ref_er[i]  = 1'b0;
        end
    endtask

    // 0x55 frame, LSB first; index 8 (data bit 7) is the fifth fall
    task automatic send_55(input int id, input int p, input bit armed,
                           input int wr_bit, input int wr_val,
                           input int rst_bit);
        logic [9:0] frame;
        int         res;
        int         lim;
        frame = {1'b1, 8'h55, 1'b0};
        lim   = (id == 0) ? (1 << W1) : (1 << W2);
        for (int b = 0; b < 10; b++) begin
            if (b == rst_bit) begin
                b1.autobaud_en = 1'b0;
                set_rxd(id, 1'b1);
                do_reset(3);
                return;
            end
            set_rxd(id, frame[b]);
            if (b == 8 && armed) begin
                res = ab_result(p);
                if (res >= 2 && res < lim) begin
                    if (id == 0) begin
                        pend_cyc = cyc + 3;
                        pend_div = res;
                    end
                    ref_div[id] = res;
                    ref_lk[id]  = 1'b1;
                end else begin
                    ref_er[id] = 1'b1;
                end
            end
            if (b == wr_bit) begin
                host_write(wr_val);
                armed = 1'b0;
                tick(p - 1);
            end else begin
                tick(p);
            end
        end
    endtask

    initial begin
        int v;
        int p;
        b1.rxd = 1'b1; b1.autobaud_en = 1'b0;
        b1.div_wr = 1'b0; b1.div_wdata = '0;
        b2.rxd = 1'b1; b2.autobaud_en = 1'b0;
        b2.div_wr = 1'b0; b2.div_wdata = '0;
        #1;
        do_reset(3);
        expect_status(0);
        expect_status(1);
        tick(100);

        host_write(10);
        tick(40);
        expect_status(0);
        host_write(0);
        tick(20);
        expect_status(0);
        host_write(1);
        tick(15);
        for (int i = 0; i < 3; i++) begin
            v = int'($urandom_range(0, 40));
            host_write(v);
            tick(int'($urandom_range(20, 80)));
            expect_status(0);
        end

        ab_rearm();
        expect_status(0);
        send_55(0, 432, 1'b1, -1, 0, -1);
        tick(60);
        expect_status(0);
        ab_rearm();
        send_55(0, 440, 1'b1, -1, 0, -1);
        tick(60);
        expect_status(0);
        for (int i = 0; i < 2; i++) begin
            p = int'($urandom_range(48, 400));
            ab_rearm();
            send_55(0, p, 1'b1, -1, 0, -1);
            tick(50);
            expect_status(0);
        end

        ab_rearm();
        send_55(0, 16, 1'b1, -1, 0, -1);
        tick(30);
        expect_status(0);

        ab_rearm();
        v = int'($urandom_range(30, 60));
        send_55(0, 432, 1'b1, 3, v, -1);
        tick(20);
        expect_status(0);
        send_55(0, 200, 1'b0, -1, 0, -1);
        tick(60);
        expect_status(0);

        ab_rearm();
        send_55(0, 300, 1'b1, -1, 0, 4);
        tick(5);
        expect_status(0);
        expect_status(1);
        tick(60);

        b2.autobaud_en = 1'b1;
        tick(3);
        set_rxd(1, 1'b0);
        tick(5);
        set_rxd(1, 1'b1);
        tick(33000);
        ref_er[1] = 1'b1;
        expect_status(1);
        send_55(1, 440, 1'b1, -1, 0, -1);
        tick(20);
        expect_status(1);
        tick(50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
